// File: rtl/sfs_pkg.sv
// Shared types and width helpers for the serial fault-simulation controller.
package sfs_pkg;

  typedef enum logic [2:0] {
    IDLE,
    G_APPLY,
    G_SAMPLE,
    F_APPLY,
    F_SAMPLE,
    REPORT,
    FIN
  } state_t;

  // Fault-id width; kept at least 1 bit so a single-fault list still has a port.
  function automatic int unsigned fw_of(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Detected-fault counter width: one extra bit so NUM_FAULTS itself fits.
  function automatic int unsigned cw_of(input int unsigned n);
    return fw_of(n) + 1;
  endfunction

endpackage

// File: rtl/sfs_golden_ram.sv
// Golden-response store: 2**AW x DW register file.
// Ports: clk/rst (async, active-high, clears contents), we/waddr/wdata write
// port, raddr/rdata asynchronous read port.
module sfs_golden_ram #(
  parameter int unsigned AW = 3,
  parameter int unsigned DW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2**AW; i++) r_mem[i] <= '0;
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/serial_fault_sim_ctrl.sv
// Serial fault-simulation controller: applies every input vector to the CUT
// fault-free to capture golden responses, then injects each fault in turn and
// reports it detected (first mismatching vector) or undetected.
// Ports: clk, rst (async, active-high), start (1-cycle pulse);
// pi_vec -> CUT inputs, po_vec <- CUT outputs; fault_en/fault_id select the
// injected fault; busy/done run status; det_valid/det_fault_id/det_flag/det_vec
// per-fault verdict; det_count detected faults in the current run.
module serial_fault_sim_ctrl
  import sfs_pkg::*;
#(
  parameter int unsigned NUM_PI     = 3,
  parameter int unsigned NUM_PO     = 2,
  parameter int unsigned NUM_FAULTS = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic [NUM_PI-1:0]               pi_vec,
  input  logic [NUM_PO-1:0]               po_vec,
  output logic                            fault_en,
  output logic [fw_of(NUM_FAULTS)-1:0]    fault_id,
  output logic                            busy,
  output logic                            done,
  output logic                            det_valid,
  output logic [fw_of(NUM_FAULTS)-1:0]    det_fault_id,
  output logic                            det_flag,
  output logic [NUM_PI-1:0]               det_vec,
  output logic [cw_of(NUM_FAULTS)-1:0]    det_count
);

  localparam int unsigned FW = fw_of(NUM_FAULTS);
  localparam int unsigned CW = cw_of(NUM_FAULTS);
  localparam logic [NUM_PI:0] LAST_VEC = (NUM_PI+1)'(2**NUM_PI - 1);
  localparam logic [FW-1:0]   LAST_F   = FW'(NUM_FAULTS - 1);

  state_t              r_state, w_next;
  logic [NUM_PI:0]     r_vec;
  logic [NUM_PO-1:0]   w_gold;
  logic                w_last_vec, w_last_f, w_mis, w_gold_we;

  assign w_last_vec = (r_vec == LAST_VEC);
  assign w_last_f   = (fault_id == LAST_F);
  // Case inequality: an X/Z response from the faulty CUT counts as a mismatch.
  assign w_mis      = (po_vec !== w_gold);
  assign w_gold_we  = (r_state == G_SAMPLE);

  sfs_golden_ram #(
    .AW(NUM_PI),
    .DW(NUM_PO)
  ) u_gold (
    .clk  (clk),
    .rst  (rst),
    .we   (w_gold_we),
    .waddr(r_vec[NUM_PI-1:0]),
    .wdata(po_vec),
    .raddr(r_vec[NUM_PI-1:0]),
    .rdata(w_gold)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:     if (start) w_next = G_APPLY;
      G_APPLY:  w_next = G_SAMPLE;
      G_SAMPLE: w_next = w_last_vec ? F_APPLY : G_APPLY;
      F_APPLY:  w_next = F_SAMPLE;
      F_SAMPLE: w_next = (w_mis || w_last_vec) ? REPORT : F_APPLY;
      REPORT:   w_next = w_last_f ? FIN : F_APPLY;
      FIN:      w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vec        <= '0;
      pi_vec       <= '0;
      fault_en     <= 1'b0;
      fault_id     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      det_valid    <= 1'b0;
      det_fault_id <= '0;
      det_flag     <= 1'b0;
      det_vec      <= '0;
      det_count    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            busy         <= 1'b1;
            det_count    <= '0;
            det_fault_id <= '0;
            det_flag     <= 1'b0;
            det_vec      <= '0;
            r_vec        <= '0;
            fault_id     <= '0;
            fault_en     <= 1'b0;
          end
        end
        G_APPLY, F_APPLY: pi_vec <= r_vec[NUM_PI-1:0];
        G_SAMPLE: begin
          if (w_last_vec) begin
            r_vec    <= '0;
            fault_en <= 1'b1;
          end else begin
            r_vec <= r_vec + (NUM_PI+1)'(1);
          end
        end
        F_SAMPLE: begin
          // Verdict registers and det_count update together so they are
          // coherent during the single REPORT cycle where det_valid is high.
          if (w_mis) begin
            det_valid    <= 1'b1;
            det_flag     <= 1'b1;
            det_vec      <= r_vec[NUM_PI-1:0];
            det_fault_id <= fault_id;
            det_count    <= det_count + CW'(1);
            fault_en     <= 1'b0;
          end else if (w_last_vec) begin
            det_valid    <= 1'b1;
            det_flag     <= 1'b0;
            det_vec      <= '0;
            det_fault_id <= fault_id;
            fault_en     <= 1'b0;
          end else begin
            r_vec <= r_vec + (NUM_PI+1)'(1);
          end
        end
        REPORT: begin
          det_valid <= 1'b0;
          if (w_last_f) begin
            done <= 1'b1;
          end else begin
            fault_id <= fault_id + FW'(1);
            r_vec    <= '0;
            fault_en <= 1'b1;
          end
        end
        FIN: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
